pc_ir_unit: RTL and testbench



---
 rtl/pc_ir_unit_pkg.sv | 38 +++
 rtl/pc_ir_unit_if.sv | 53 +++++
 rtl/pc_ir_unit_branch_cond_eval.sv | 32 +++
 rtl/pc_ir_unit.sv | 103 ++++++++++
 tb/tb_pc_ir_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pc_ir_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_ctrl_pkg
// Purpose: Encodings shared by the multicycle controller and pc_ir_unit.
//          Holds the BranchCond and PCSource codes and the bit positions of
//          the instruction fields.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_EQ  = 2'b00,
    BR_NE  = 2'b01,
    BR_LTZ = 2'b10,
    BR_GTZ = 2'b11
  } br_cond_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_HOLD   = 2'b11
  } pc_src_e;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

endpackage
`default_nettype wire

// File: rtl/pc_ir_unit_if.sv
`default_nettype none
// ============================================================================
// Module : pc_ir_unit_if
// Purpose: Bundle between the controller/datapath and pc_ir_unit.
//          master: drives sequencing strobes, memory/ALU data and flags;
//                  receives PC, decoded fields, MDR/ALUOut, counters.
//          slave : pc_ir_unit side.
// Ports  : PCWrite, PCWriteCond, BranchCond[1:0], PCSource[1:0], IRWrite,
//          MemData, ALUResult, Zero, Negative (to slave);
//          PC, opcode, rs, rt, rd, imm16, target26, MDR, ALUOut,
//          InstrCount, PCMisalign (from slave)
// Rev    : 1.0  initial release
// ============================================================================
interface pc_ir_unit_if #(
  parameter int DATA_W = 32
);
  logic              PCWrite;
  logic              PCWriteCond;
  logic [1:0]        BranchCond;
  logic [1:0]        PCSource;
  logic              IRWrite;
  logic [DATA_W-1:0] MemData;
  logic [DATA_W-1:0] ALUResult;
  logic              Zero;
  logic              Negative;

  logic [DATA_W-1:0] PC;
  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm16;
  logic [25:0]       target26;
  logic [DATA_W-1:0] MDR;
  logic [DATA_W-1:0] ALUOut;
  logic [31:0]       InstrCount;
  logic              PCMisalign;

  modport master (
    output PCWrite, PCWriteCond, BranchCond, PCSource, IRWrite,
           MemData, ALUResult, Zero, Negative,
    input  PC, opcode, rs, rt, rd, imm16, target26, MDR, ALUOut,
           InstrCount, PCMisalign
  );

  modport slave (
    input  PCWrite, PCWriteCond, BranchCond, PCSource, IRWrite,
           MemData, ALUResult, Zero, Negative,
    output PC, opcode, rs, rt, rd, imm16, target26, MDR, ALUOut,
           InstrCount, PCMisalign
  );
endinterface
`default_nettype wire

// File: rtl/pc_ir_unit_branch_cond_eval.sv
`default_nettype none
// ============================================================================
// Module : branch_cond_eval
// Purpose: Combinational branch condition decode from the ALU flags.
// Ports  : BranchCond[1:0] in  condition select (EQ/NE/LTZ/GTZ)
//          Zero           in  ALU result == 0
//          Negative       in  ALU result sign
//          cond_true      out selected condition holds
// Rev    : 1.0  initial release
// ============================================================================
module branch_cond_eval
  import cpu_ctrl_pkg::*;
(
  input  logic [1:0] BranchCond,
  input  logic       Zero,
  input  logic       Negative,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (br_cond_e'(BranchCond))
      BR_EQ:   cond_true = Zero;
      BR_NE:   cond_true = ~Zero;
      BR_LTZ:  cond_true = Negative;
      BR_GTZ:  cond_true = ~Negative & ~Zero;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_ir_unit.sv
`default_nettype none
// ============================================================================
// Module : pc_ir_unit
// Purpose: Multicycle datapath state: PC, IR, MDR, ALUOut, fetched-instruction
//          counter and sticky PC-misalignment flag. Decoded IR fields are
//          pure slices of the IR, so every output is registered.
// Ports  : Clk   in  rising-edge clock
//          Reset in  synchronous, active-high
//          bus   slave modport of pc_ir_unit_if (strobes, data, outputs)
// Rev    : 1.0  initial release
// ============================================================================
module pc_ir_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input logic         Clk,
  input logic         Reset,
  pc_ir_unit_if.slave bus
);

  logic [DATA_W-1:0] pc_q,     pc_d;
  logic [DATA_W-1:0] ir_q,     ir_d;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] alu_out_q;
  logic [31:0]       icnt_q,   icnt_d;
  logic              misal_q,  misal_d;

  logic              cond_true;
  logic              pc_update;
  logic [DATA_W-1:0] next_pc;

  branch_cond_eval u_branch_cond_eval (
    .BranchCond (bus.BranchCond),
    .Zero       (bus.Zero),
    .Negative   (bus.Negative),
    .cond_true  (cond_true)
  );

  // PCWrite alone is sufficient, so it overrides a false branch condition.
  assign pc_update = bus.PCWrite | (bus.PCWriteCond & cond_true);

  always_comb begin
    next_pc = pc_q;
    case (pc_src_e'(bus.PCSource))
      PCS_ALU:    next_pc = bus.ALUResult;
      PCS_ALUOUT: next_pc = alu_out_q;
      PCS_JUMP:   next_pc = {pc_q[DATA_W-1:DATA_W-4], ir_q[TGT_MSB:0], 2'b00};
      default:    next_pc = pc_q;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    icnt_d  = icnt_q;
    misal_d = misal_q;
    if (pc_update) begin
      // The PC itself is always word aligned; low bits only feed the flag.
      pc_d = {next_pc[DATA_W-1:2], 2'b00};
      if ((pc_src_e'(bus.PCSource) != PCS_HOLD) && (next_pc[1:0] != 2'b00)) begin
        misal_d = 1'b1;
      end
    end
    if (bus.IRWrite) begin
      ir_d   = bus.MemData;
      icnt_d = icnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q      <= PC_RESET[DATA_W-1:0];
      ir_q      <= '0;
      mdr_q     <= '0;
      alu_out_q <= '0;
      icnt_q    <= '0;
      misal_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= bus.MemData;
      alu_out_q <= bus.ALUResult;
      icnt_q    <= icnt_d;
      misal_q   <= misal_d;
    end
  end

  assign bus.PC         = pc_q;
  assign bus.opcode     = ir_q[OP_MSB:OP_LSB];
  assign bus.rs         = ir_q[RS_MSB:RS_LSB];
  assign bus.rt         = ir_q[RT_MSB:RT_LSB];
  assign bus.rd         = ir_q[RD_MSB:RD_LSB];
  assign bus.imm16      = ir_q[IMM_MSB:0];
  assign bus.target26   = ir_q[TGT_MSB:0];
  assign bus.MDR        = mdr_q;
  assign bus.ALUOut     = alu_out_q;
  assign bus.InstrCount = icnt_q;
  assign bus.PCMisalign = misal_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_ir_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_pc_ir_unit
// Purpose: Directed self-checking bench for pc_ir_unit.
// Ports  : none
// Rev    : 1.0  initial release
// ============================================================================
module tb_pc_ir_unit;
  import cpu_ctrl_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_pc;

  pc_ir_unit_if bus ();

  pc_ir_unit #(.DATA_W(32), .PC_RESET(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchCond  = 2'b00;
    bus.PCSource    = 2'b11;
    bus.IRWrite     = 1'b0;
    bus.Zero        = 1'b0;
    bus.Negative    = 1'b0;
  endtask

  // Latch a target into ALUOut, then present a conditional PC write.
  task automatic do_branch(input string tag, input logic [1:0] bc, input logic z,
                           input logic n, input logic [31:0] tgt, input logic pcw,
                           input logic taken);
    idle();
    bus.ALUResult = tgt;
    tick();
    bus.ALUResult   = 32'h0000_0BAD;
    bus.PCWriteCond = 1'b1;
    bus.PCWrite     = pcw;
    bus.BranchCond  = bc;
    bus.PCSource    = 2'b01;
    bus.Zero        = z;
    bus.Negative    = n;
    tick();
    if (taken) exp_pc = tgt;
    chk(tag, bus.PC, exp_pc);
    idle();
  endtask

  initial begin
    idle();
    bus.MemData   = 32'h0;
    bus.ALUResult = 32'h0;
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state held across idle cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_pc",     bus.PC, 32'h0);
      chk("rst_opcode", {26'd0, bus.opcode}, 32'h0);
      chk("rst_icnt",   bus.InstrCount, 32'h0);
      chk("rst_misal",  {31'd0, bus.PCMisalign}, 32'h0);
      chk("rst_mdr",    bus.MDR, 32'h0);
      chk("rst_aluout", bus.ALUOut, 32'h0);
    end

    // Fetch lw r2,4(r1)
    bus.MemData   = 32'h8C22_0004;
    bus.IRWrite   = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h4;
    tick();
    chk("f_opcode", {26'd0, bus.opcode}, 32'h23);
    chk("f_rs",     {27'd0, bus.rs}, 32'd1);
    chk("f_rt",     {27'd0, bus.rt}, 32'd2);
    chk("f_rd",     {27'd0, bus.rd}, 32'd0);
    chk("f_imm16",  {16'd0, bus.imm16}, 32'h4);
    chk("f_tgt26",  {6'd0, bus.target26}, 32'h0220004);
    chk("f_pc",     bus.PC, 32'h4);
    chk("f_icnt",   bus.InstrCount, 32'd1);
    chk("f_mdr",    bus.MDR, 32'h8C22_0004);
    chk("f_aluout", bus.ALUOut, 32'h4);
    exp_pc = 32'h4;

    // IR holds without IRWrite; MDR follows MemData every cycle
    idle();
    bus.MemData   = 32'hFFFF_FFFF;
    bus.ALUResult = 32'h1234_5678;
    tick();
    chk("hold_opcode", {26'd0, bus.opcode}, 32'h23);
    chk("hold_icnt",   bus.InstrCount, 32'd1);
    chk("mdr_follow",  bus.MDR, 32'hFFFF_FFFF);
    chk("alu_follow",  bus.ALUOut, 32'h1234_5678);
    chk("hold_pc",     bus.PC, 32'h4);

    // Branch conditions, each with taken and not-taken flags
    do_branch("beq_t",  2'b00, 1'b1, 1'b0, 32'h40,  1'b0, 1'b1);
    do_branch("beq_nt", 2'b00, 1'b0, 1'b0, 32'h80,  1'b0, 1'b0);
    do_branch("bne_t",  2'b01, 1'b0, 1'b0, 32'h100, 1'b0, 1'b1);
    do_branch("bne_nt", 2'b01, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
    do_branch("ltz_t",  2'b10, 1'b0, 1'b1, 32'h300, 1'b0, 1'b1);
    do_branch("ltz_nt", 2'b10, 1'b0, 1'b0, 32'h400, 1'b0, 1'b0);
    do_branch("gtz_t",  2'b11, 1'b0, 1'b0, 32'h500, 1'b0, 1'b1);
    do_branch("gtz_nz", 2'b11, 1'b1, 1'b0, 32'h600, 1'b0, 1'b0);
    do_branch("gtz_nn", 2'b11, 1'b0, 1'b1, 32'h700, 1'b0, 1'b0);
    do_branch("pcw_win", 2'b00, 1'b0, 1'b0, 32'h800, 1'b1, 1'b1);
    chk("br_misal", {31'd0, bus.PCMisalign}, 32'h0);

    // Jump: set PC and load a j-format instruction in the same cycle
    bus.PCWrite   = 1'b1;
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h1000_0010;
    bus.IRWrite   = 1'b1;
    bus.MemData   = 32'h0800_0100;
    tick();
    chk("j_setpc", bus.PC, 32'h1000_0010);
    chk("j_tgt26", {6'd0, bus.target26}, 32'h0000100);
    chk("j_opcode", {26'd0, bus.opcode}, 32'h02);
    idle();
    bus.PCWrite  = 1'b1;
    bus.PCSource = 2'b10;
    tick();
    chk("j_pc", bus.PC, 32'h1000_0400);

    // Hold source: no PC change, no flag even with odd data elsewhere
    bus.PCSource  = 2'b11;
    bus.ALUResult = 32'h0000_0003;
    tick();
    chk("hold_src_pc",    bus.PC, 32'h1000_0400);
    chk("hold_src_misal", {31'd0, bus.PCMisalign}, 32'h0);

    // Misaligned update: PC forced aligned, flag sticky
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h0000_0006;
    tick();
    chk("mis_pc",    bus.PC, 32'h4);
    chk("mis_flag",  {31'd0, bus.PCMisalign}, 32'h1);
    idle();
    tick();
    tick();
    chk("mis_sticky", {31'd0, bus.PCMisalign}, 32'h1);
    chk("icnt_before_wrap", bus.InstrCount, 32'd2);

    // Counter wrap
    force dut.icnt_q = 32'hFFFF_FFFE;
    #2;
    release dut.icnt_q;
    bus.IRWrite = 1'b1;
    tick();
    chk("icnt_max",  bus.InstrCount, 32'hFFFF_FFFF);
    tick();
    chk("icnt_wrap", bus.InstrCount, 32'h0);

    // Reset wins over simultaneous strobes
    Reset         = 1'b1;
    bus.PCWrite   = 1'b1;
    bus.PCSource  = 2'b00;
    bus.ALUResult = 32'h44;
    bus.IRWrite   = 1'b1;
    bus.MemData   = 32'h8C22_0004;
    tick();
    chk("rp_pc",     bus.PC, 32'h0);
    chk("rp_opcode", {26'd0, bus.opcode}, 32'h0);
    chk("rp_icnt",   bus.InstrCount, 32'h0);
    chk("rp_misal",  {31'd0, bus.PCMisalign}, 32'h0);
    chk("rp_mdr",    bus.MDR, 32'h0);
    chk("rp_aluout", bus.ALUOut, 32'h0);
    Reset = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
